// File: rtl/ahb_apb_pkg.sv
// Shared AHB-Lite / APB3 encodings and the APB-to-AHB bridge state type.
// Constants only; no logic, no latency, no flow control.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } bridge_state_e;

endpackage

// File: rtl/apb3_to_ahb_bridge.sv
// APB3 slave issuing one single-beat AHB-Lite word transfer per APB access; 4 cycles with a zero-wait slave.
// APB is back-pressured through PREADY; AHB HREADY stalls hold the current phase, one transfer in flight.
module apb3_to_ahb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int         FAMILY      = 17,
    parameter logic [7:0] HADDR_UPPER = 8'h40
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [23:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    bridge_state_e state_q, state_d;
    logic [31:0]   haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic          resp_err;

    // Byte-lane bits of PADDR and the family code carry no function here.
    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], FAMILY[0]};

    assign resp_err = (HRESP != HRESP_OKAY);

    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        err_d     = err_q;
        abort_d   = abort_q;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (PSEL && !PENABLE) begin
                    haddr_d  = {HADDR_UPPER, PADDR[23:2], 2'b00};
                    hwrite_d = PWRITE;
                    hwdata_d = PWDATA;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!PSEL) begin
                    abort_d = 1'b1;
                end
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    err_d    = 1'b0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!PSEL) begin
                    abort_d = 1'b1;
                end
                if (resp_err) begin
                    err_d = 1'b1;
                end
                if (HREADY) begin
                    // An APB master that walked away gets no response; the AHB beat still finishes.
                    if (abort_q || !PSEL) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (!hwrite_q) begin
                            prdata_d = (err_q || resp_err) ? 32'h0 : HRDATA;
                        end
                        pslverr_d = err_q | resp_err;
                        pready_d  = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            haddr_q   <= 32'h0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= 32'h0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
        end
    end

    assign HADDR   = haddr_q;
    assign HTRANS  = htrans_q;
    assign HWRITE  = hwrite_q;
    assign HWDATA  = hwdata_q;
    assign HSIZE   = HSIZE_WORD;
    assign HBURST  = HBURST_SINGLE;
    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb3_to_ahb_bridge.sv
// Scoreboard bench: APB stimulus pushes expected AHB beats and APB responses,
// an AHB slave model and an APB monitor pop and compare them.
module tb_apb3_to_ahb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [23:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HREADY;
    logic [2:0]  HSIZE, HBURST;

    apb3_to_ahb_bridge #(.FAMILY(17), .HADDR_UPPER(8'h40)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } ahb_exp_t;
    typedef struct { logic [31:0] rdata; logic err; } apb_exp_t;

    ahb_exp_t exp_ahb[$];
    apb_exp_t exp_apb[$];
    int checks = 0;
    int failures = 0;

    int          cfg_aw = 0, cfg_dw = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          ph, awc, dwc;
    logic        err_half;
    ahb_exp_t    cur;
    logic        last_pready = 1'b0;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AHB slave model with per-transfer wait/error profile
    initial begin
        ph = 0; awc = 0; dwc = 0; err_half = 1'b0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = JUNK;
        cur.addr = 32'h0; cur.wr = 1'b0; cur.wdata = 32'h0;
        forever begin
            @(posedge HCLK); #1;
            if (HRESET) begin
                ph = 0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = JUNK;
            end else begin
                if (ph == 1 && HREADY) begin
                    ph = 2; dwc = cfg_dw; err_half = 1'b0;
                end else if (ph == 2 && HREADY) begin
                    ph = 0;
                end
                if (ph == 0 && HTRANS == 2'b10) begin
                    if (exp_ahb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_nonseq: got haddr %h expected no transfer", HADDR);
                    end else begin
                        cur = exp_ahb.pop_front();
                        chk("haddr", HADDR, cur.addr);
                        chk("hwrite", {31'h0, HWRITE}, {31'h0, cur.wr});
                    end
                    ph = 1; awc = cfg_aw;
                end
                case (ph)
                    1: begin
                        chk("addr_htrans", {30'h0, HTRANS}, 32'h2);
                        chk("addr_haddr_stable", HADDR, cur.addr);
                        HRESP = 2'b00; HRDATA = JUNK;
                        if (awc > 0) begin HREADY = 1'b0; awc--; end
                        else HREADY = 1'b1;
                    end
                    2: begin
                        chk("data_htrans_idle", {30'h0, HTRANS}, 32'h0);
                        if (cur.wr) chk("hwdata", HWDATA, cur.wdata);
                        if (dwc > 0) begin
                            HREADY = 1'b0; HRESP = 2'b00; HRDATA = JUNK; dwc--;
                        end else if (cfg_err && !err_half) begin
                            HREADY = 1'b0; HRESP = 2'b01; HRDATA = cfg_rdata; err_half = 1'b1;
                        end else begin
                            HREADY = 1'b1; HRESP = cfg_err ? 2'b01 : 2'b00; HRDATA = cfg_rdata;
                        end
                    end
                    default: begin
                        HREADY = 1'b1; HRESP = 2'b00; HRDATA = JUNK;
                    end
                endcase
            end
        end
    end

    // APB response monitor
    always @(negedge HCLK) begin
        if (last_pready) chk("pready_one_cycle", {30'h0, PREADY, PSLVERR}, 32'h0);
        if (PREADY) begin
            if (exp_apb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pready: got pready 1 expected 0");
            end else begin
                apb_exp_t e;
                e = exp_apb.pop_front();
                chk("prdata", PRDATA, e.rdata);
                chk("pslverr", {31'h0, PSLVERR}, {31'h0, e.err});
            end
        end
        last_pready = PREADY;
    end

    task automatic apb_xfer(input logic wr, input logic [23:0] addr, input logic [31:0] wdata,
                            input int aw, input int dw, input logic err, input logic [31:0] rdata,
                            input logic [31:0] exp_haddr, input logic [31:0] exp_prdata,
                            input int exp_lat);
        ahb_exp_t a;
        apb_exp_t p;
        int k;
        cfg_aw = aw; cfg_dw = dw; cfg_err = err; cfg_rdata = rdata;
        a.addr = exp_haddr; a.wr = wr; a.wdata = wdata;
        p.rdata = exp_prdata; p.err = err;
        exp_ahb.push_back(a);
        exp_apb.push_back(p);
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        k = 0;
        do begin
            @(negedge HCLK); k++;
        end while (!PREADY && k < 40);
        chk("access_cycles", k, exp_lat);
    endtask

    task automatic apb_idle();
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        ahb_exp_t a;
        int k;
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 24'h0; PWDATA = 32'h0;
        #3;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", {31'h0, PREADY}, 32'h0);
        chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("hsize", {29'h0, HSIZE}, 32'h2);
        chk("hburst", {29'h0, HBURST}, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        // zero-wait write
        apb_xfer(1'b1, 24'h000104, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, 32'h40000104, 32'h0, 3);
        apb_idle();
        // read, two data wait states
        apb_xfer(1'b0, 24'h000200, 32'h0, 0, 2, 1'b0, 32'h12345678, 32'h40000200, 32'h12345678, 5);
        apb_idle();
        // two-cycle ERROR on a read
        apb_xfer(1'b0, 24'h000300, 32'h0, 0, 0, 1'b1, 32'h99999999, 32'h40000300, 32'h0, 4);
        apb_idle();
        // address phase stalled for 3 cycles
        apb_xfer(1'b1, 24'h000010, 32'hA5A5A5A5, 3, 0, 1'b0, 32'h0, 32'h40000010, 32'h0, 6);
        apb_idle();
        // back-to-back write then read, unaligned PADDR
        apb_xfer(1'b1, 24'h000023, 32'h0BADF00D, 0, 0, 1'b0, 32'h0, 32'h40000020, 32'h0, 3);
        apb_xfer(1'b0, 24'h000047, 32'h0, 0, 0, 1'b0, 32'hCAFEF00D, 32'h40000044, 32'hCAFEF00D, 3);

        // access phase with no preceding setup must be ignored
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 24'h000080;
        repeat (3) @(posedge HCLK);
        #1; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        chk("noset_htrans", {30'h0, HTRANS}, 32'h0);
        chk("noset_pready", {31'h0, PREADY}, 32'h0);

        // PSEL dropped after the first access cycle
        cfg_aw = 0; cfg_dw = 2; cfg_err = 1'b0; cfg_rdata = 32'h11111111;
        a.addr = 32'h40000050; a.wr = 1'b0; a.wdata = 32'h0;
        exp_ahb.push_back(a);
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 24'h000050;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (8) @(posedge HCLK);
        @(negedge HCLK);
        chk("abort_prdata_kept", PRDATA, 32'hCAFEF00D);
        chk("abort_ahb_done", ph, 0);

        // reset asserted during the data phase
        cfg_aw = 0; cfg_dw = 5; cfg_err = 1'b0; cfg_rdata = 32'h33333333;
        a.addr = 32'h40000060; a.wr = 1'b0; a.wdata = 32'h0;
        exp_ahb.push_back(a);
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 24'h000060;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        k = 0;
        while (ph != 2 && k < 20) begin
            @(negedge HCLK); k++;
        end
        chk("reach_data_phase", ph, 2);
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        chk("midrst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("midrst_pready", {31'h0, PREADY}, 32'h0);
        chk("midrst_haddr", HADDR, 32'h0);
        chk("midrst_prdata", PRDATA, 32'h0);
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b0;

        // normal operation after reset release
        apb_xfer(1'b1, 24'h000070, 32'h55AA55AA, 0, 0, 1'b0, 32'h0, 32'h40000070, 32'h0, 3);
        apb_idle();
        apb_xfer(1'b0, 24'h000070, 32'h0, 0, 0, 1'b0, 32'h77778888, 32'h40000070, 32'h77778888, 3);
        apb_idle();

        repeat (4) @(negedge HCLK);
        chk("ahb_queue_drained", exp_ahb.size(), 0);
        chk("apb_queue_drained", exp_apb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb3_to_ahb_bridge.md
Name: apb3_to_ahb_bridge

Overview:
- APB3 slave that converts each APB3 transfer into one single-beat AHB-Lite word transfer as bus master.
- It is the reverse-direction companion to the existing AHB-to-APB3 bridge.
- Lets APB-side agents (debug/config ports, APB-only masters) reach AHB-resident memory and peripherals.
- Single clock domain; one outstanding transfer at a time.

Parameters:
- FAMILY, 17, device family code; carried for tool flow, no functional effect.
- HADDR_UPPER, 8'h40, drives HADDR[31:24]; HADDR[23:0] = {PADDR[23:2], 2'b00}.

Ports:
- HCLK  in  1  bridge clock (APB and AHB share it)
- HRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  APB3 select
- PENABLE  in  1  APB3 enable
- PWRITE  in  1  APB3 direction, 1 = write
- PADDR  in  24  APB3 byte address
- PWDATA  in  32  APB3 write data
- PRDATA  out  32  APB3 read data
- PREADY  out  1  APB3 transfer complete
- PSLVERR  out  1  APB3 error, valid only with PREADY
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type; only IDLE = 00 or NONSEQ = 10
- HWRITE  out  1  AHB direction
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  2  AHB response; 00 = OKAY, 01 = ERROR, others treated as ERROR

Behaviour:
- Reset values (asserted asynchronously on HRESET): PRDATA = 0, PREADY = 0, PSLVERR = 0, HADDR = 0, HTRANS = IDLE, HWRITE = 0, HWDATA = 0. State = IDLE, error flag = 0.
- FSM IDLE:
  - On PSEL & !PENABLE (APB setup), register HADDR, HWRITE and HWDATA from PADDR, PWRITE and PWDATA.
  - Drive HTRANS = NONSEQ from the next cycle; go to ADDR.
- FSM ADDR:
  - Hold HTRANS = NONSEQ, HADDR and HWRITE stable until HREADY = 1.
  - On HREADY = 1: HTRANS <= IDLE, clear error flag, go to DATA.
- FSM DATA:
  - HWDATA held stable throughout.
  - Any cycle with HRESP != OKAY sets the error flag; this covers both cycles of the two-cycle ERROR response.
  - On HREADY = 1, go to RESP and register:
    - PRDATA <= HRDATA for an OKAY read, otherwise 0.
    - PSLVERR <= error flag OR HRESP != OKAY.
- FSM RESP:
  - PREADY = 1 for exactly one cycle, with PSLVERR as registered; then go to IDLE.
  - PREADY deasserts and PSLVERR returns to 0 on the following cycle.
  - PRDATA holds its value until the next read completes.
- Latency: with a zero-wait AHB slave, an APB transfer takes 4 cycles (setup, then PREADY in the 3rd access cycle), i.e. 2 APB wait states. Each AHB wait state adds one cycle.
- No pipelining: no new NONSEQ is issued before the current data phase completes, so HTRANS never shows back-to-back NONSEQ.
- PSEL dropped mid-transfer (APB protocol violation):
  - The AHB transfer still completes; AHB rules forbid abandoning it.
  - Result is discarded; PREADY is not asserted; return to IDLE.
- PSEL & PENABLE while the FSM is IDLE without a prior setup: ignored, PREADY stays 0.
- HRESET mid-transfer: all outputs return to reset values immediately; no AHB completion is attempted.
- PADDR[1:0] is ignored; the address is always word-aligned.

Decomposition:
- Shared package (ahb_apb_pkg):
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ
  - HRESP encodings OKAY/ERROR/RETRY/SPLIT
  - HSIZE_WORD, HBURST_SINGLE
  - bridge FSM state enum {IDLE, ADDR, DATA, RESP}
- Single module; no sub-module is warranted. Estimated size is about 150 lines.

Test Plan:
- Zero-wait write: PADDR = 24'h000104, PWDATA = 32'hDEADBEEF, HREADY always 1 -> one NONSEQ with HADDR = 32'h40000104, HWRITE = 1; HWDATA = DEADBEEF in the data phase; PREADY on the 3rd PENABLE cycle; PSLVERR = 0.
- Read with 2 AHB data wait states: HRDATA = 32'h12345678 -> PREADY 2 cycles later than zero-wait; PRDATA = 12345678; HTRANS = IDLE throughout the data phase.
- Two-cycle ERROR on a read: cycle 1 HREADY = 0, HRESP = 01; cycle 2 HREADY = 1, HRESP = 01 -> PREADY = 1, PSLVERR = 1, PRDATA = 0.
- Address phase stalled by HREADY = 0 for 3 cycles -> HTRANS = NONSEQ and HADDR held stable for all 3 cycles; exactly one transfer issued.
- Back-to-back APB write then read -> two separate NONSEQ beats separated by at least one IDLE; correct PREADY for each; PADDR[1:0] = 2'b11 yields HADDR[1:0] = 00.
- Assert HRESET during DATA -> HTRANS = IDLE and PREADY = 0 immediately; the next APB transfer after reset release completes normally.
